out_port_uart_tx: RTL and testbench
===================================

# out_port_uart_tx

Output-port serializer that sits directly downstream of the 16-bit pipelined MIPS core's write-back stage. It captures every word the core writes on an OUT instruction into a small FIFO. It transmits each word on a single UART line as two 8N1 frames, low byte first. The core never stalls: when the FIFO is full, writes are dropped and flagged.

## Interface

Parameters:
- `n`, 16: data word width. Must be 16; two bytes per word.
- `DEPTH`, 8: FIFO depth in words. Power of two, ≥ 2.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit. ≥ 2.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-low. Low clears all state immediately.
- `wr_en`, in, 1: write strobe (WB-stage OUT qualifier), one word per asserted cycle.
- `wr_data`, in, n: word to transmit (WB out_port value).
- `tx`, out, 1: UART serial line, registered, idle high.
- `busy`, out, 1: high whenever the transmit FSM is not in IDLE.
- `empty`, out, 1: FIFO holds no words.
- `full`, out, 1: FIFO holds DEPTH words.
- `count`, out, $clog2(DEPTH)+1: number of words held in the FIFO.
- `overflow`, out, 1: sticky flag; set when a write is dropped; cleared only by reset.

## Operation

- **Reset values (rst low, asynchronous):**
  - `tx`=1, `busy`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0.
  - FSM=IDLE, read/write pointers=0, `byte_sel`=0, bit and clock counters=0.
  - FIFO contents are discarded.
- **FIFO write:** if `wr_en` and !`full` (evaluated on the pre-edge `count`), store `wr_data` at the write pointer. The pointer wraps modulo DEPTH.
- **Write while full:** the word is dropped and `overflow` is set. This holds even if a pop happens on the same edge. `count` and the pointers are unchanged by the dropped write.
- **Simultaneous write and pop (not full):** both take effect; `count` is unchanged.
- **`count`, `full`, `empty`:** registered, consistent with the pointers after every edge. Never wraps past DEPTH and never goes below 0.
- **FSM states:**
  - **IDLE:**
    - `tx`=1.
    - If !`empty`: pop the head word into the 16-bit shift holding register, set `byte_sel`=0, go to START.
  - **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - **DATA:**
    - `tx` = bit[index] of the current byte, LSB first. The current byte is the low byte when `byte_sel`=0 and the high byte when `byte_sel`=1.
    - Each bit is held for CLKS_PER_BIT cycles.
    - After bit 7, go to STOP.
  - **STOP:**
    - `tx`=1 for CLKS_PER_BIT cycles.
    - Then, if `byte_sel`=0: set `byte_sel`=1 and go to START.
    - Otherwise go to IDLE.
- **Word retention:** a popped word is fully transmitted. Later writes and a full FIFO never disturb the in-flight word; only reset does.
- **Parity:** none. There is no flow-control input.

## Timing

- **Write to start bit:** `wr_en` sampled at edge E into an empty FIFO with the FSM in IDLE. `empty` falls after E. The FSM pops at E+1. `tx` is low and `busy` is high from E+1.
- **Frame length:** one byte frame is exactly 10·CLKS_PER_BIT cycles (start, 8 data, stop).
- **Word length:** the low and high frames are back-to-back with no gap, so one word is 20·CLKS_PER_BIT cycles.
- **Back-to-back words:** STOP of the high byte → IDLE (1 cycle, `tx`=1) → pop. The inter-word gap is therefore 20·CLKS_PER_BIT+1 cycles from start bit to start bit.
- **Pop timing:** `count` decrements after the IDLE pop edge, not at the end of transmission.
- **Reset mid-frame:** `tx` goes to 1 asynchronously. After rst is released, nothing transmits until a new write arrives.

## Test plan

Run with CLKS_PER_BIT=4 and DEPTH=8.

1. **Reset:** hold rst low, pulse wr_en with data → tx=1, busy=0, empty=1, count=0, overflow=0 throughout.
2. **Single word:** write 16'hA55A at edge E → tx low from E+1. Bit sequence, 4 cycles each: 0,0,1,0,1,1,0,1,0,1 (0x5A), then 0,1,0,1,0,0,1,0,1,1 (0xA5). busy falls at E+81. empty=1 after E+1.
3. **Back-to-back:** write 16'h0001 then 16'hFFFF on consecutive cycles → second start bit exactly 81 cycles after the first. Decoded bytes are 01,00,FF,FF.
4. **Overflow:** ten writes on consecutive cycles with data 0..9 → full=1 and count=8 after the 9th write. Word 9 is dropped and overflow=1. Bytes decoded in order are words 0..8.
5. **Simultaneous write and pop:** FIFO holds 1 word with FSM in STOP of the high byte. Write a new word on the IDLE pop cycle → count stays 1, and both words transmit in order.
6. **Reset mid-frame:** assert rst during DATA of the low byte → tx=1 immediately and count=0. After release, a write of 16'h00C3 transmits correctly from the next start bit.

Source files
------------

// File: rtl/out_port_uart_tx.sv
// Output-port serializer: buffers words written by the core's OUT instruction
// in a small FIFO and sends each one as two 8N1 UART frames, low byte first.
module out_port_uart_tx #(
  parameter int n            = 16,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [n-1:0]             wr_data,
  output logic                     tx,
  output logic                     busy,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   clk_cnt, clk_cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic            byte_sel, byte_sel_d;
  logic [n-1:0]    hold, hold_d;
  logic            tx_d;
  logic [7:0]      cur_byte;
  logic            push, pop;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count_d;
  logic [n-1:0]    mem [DEPTH];

  assign push    = wr_en && !full;
  assign count_d = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign busy    = (state != IDLE);

  // Storage needs no reset: contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    state_d    = state;
    clk_cnt_d  = clk_cnt;
    bit_idx_d  = bit_idx;
    byte_sel_d = byte_sel;
    hold_d     = hold;
    pop        = 1'b0;
    tx_d       = 1'b1;
    cur_byte   = 8'h00;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          hold_d     = mem[rd_ptr];
          byte_sel_d = 1'b0;
          clk_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_d = '0;
          if (!byte_sel) begin
            byte_sel_d = 1'b1;
            state_d    = START;
          end else begin
            state_d    = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered, so it is derived from where the FSM is going next.
    cur_byte = byte_sel_d ? hold_d[15:8] : hold_d[7:0];
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= 3'd0;
      byte_sel <= 1'b0;
      hold     <= '0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      clk_cnt  <= clk_cnt_d;
      bit_idx  <= bit_idx_d;
      byte_sel <= byte_sel_d;
      hold     <= hold_d;
      tx       <= tx_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_d;
      full     <= (count_d == FULL_CNT);
      empty    <= (count_d == '0);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Self-checking bench for out_port_uart_tx: a word-level FIFO/timing model
// predicts tx, busy and the FIFO flags every cycle.
module tb_out_port_uart_tx;

  localparam int C        = 4;
  localparam int D        = 8;
  localparam int WORD_CYC = 20 * C;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx, busy, empty, full, overflow;
  logic [3:0]  count;

  int          total = 0;
  int          bad = 0;
  int          now = 0;
  int          busy_until = 0;
  int          pop_t = 0;
  logic [15:0] cur_word = '0;
  logic [15:0] mq[$];
  logic        m_ovf = 1'b0;

  out_port_uart_tx #(.n(16), .DEPTH(D), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .tx(tx), .busy(busy), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Line level of a 20-slot word: start, 8 data LSB first, stop, per byte.
  function automatic logic frame_bit(input logic [15:0] w, input int idx);
    int j;
    logic [7:0] b;
    j = idx % 10;
    b = (idx < 10) ? w[7:0] : w[15:8];
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic exp_tx;
    exp_tx = (now < busy_until) ? frame_bit(cur_word, (now - pop_t) / C) : 1'b1;
    checkOutput("tx", tx, exp_tx);
    checkOutput("busy", busy, now < busy_until);
    checkOutput("count", count, mq.size());
    checkOutput("full", full, mq.size() == D);
    checkOutput("empty", empty, mq.size() == 0);
    checkOutput("overflow", overflow, m_ovf);
  endtask

  task automatic checkReset();
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_overflow", overflow, 0);
  endtask

  // One clock: drive inputs at a falling edge, advance the model across the
  // rising edge, then compare at the next falling edge.
  task automatic applyStimulus(input logic we, input logic [15:0] d);
    int pre;
    wr_en = we;
    wr_data = d;
    @(negedge clk);
    now++;
    pre = mq.size();
    if (now > busy_until && pre > 0) begin
      cur_word = mq.pop_front();
      pop_t = now;
      busy_until = now + WORD_CYC;
    end
    if (we) begin
      if (pre == D) m_ovf = 1'b1;
      else mq.push_back(d);
    end
    wr_en = 1'b0;
    checkAll();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 16'h0000);
  endtask

  task automatic resetPhase(input int cycles);
    rst = 1'b0;
    #1;
    checkReset();
    for (int i = 0; i < cycles; i++) begin
      wr_en = 1'b1;
      wr_data = 16'($urandom);
      @(negedge clk);
      now++;
      checkReset();
    end
    wr_en = 1'b0;
    rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    busy_until = now;
  endtask

  initial begin
    int fall;
    int rise1;
    int rise2;
    logic prev_busy;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    @(negedge clk);

    $display("[TB] reset with write pulses");
    resetPhase(5);

    $display("[TB] single word A55A");
    applyStimulus(1'b1, 16'hA55A);
    checkOutput("first_empty", empty, 0);
    fall = -1;
    for (int k = 1; k <= 90; k++) begin
      applyStimulus(1'b0, 16'h0000);
      if (k == 1) checkOutput("start_tx", tx, 0);
      if (!busy && fall < 0) fall = k;
    end
    checkOutput("busy_fall", fall, 81);

    $display("[TB] back-to-back words");
    applyStimulus(1'b1, 16'h0001);
    applyStimulus(1'b1, 16'hFFFF);
    rise1 = -1;
    rise2 = -1;
    prev_busy = busy;
    if (busy) rise1 = now;
    for (int k = 0; k < 180; k++) begin
      applyStimulus(1'b0, 16'h0000);
      if (busy && !prev_busy) rise2 = now;
      prev_busy = busy;
    end
    checkOutput("word_gap", rise2 - rise1, 81);

    $display("[TB] overflow burst");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 16'(k));
      if (k == 8) begin
        checkOutput("full_after9", full, 1);
        checkOutput("count_after9", count, 8);
      end
    end
    checkOutput("overflow_set", overflow, 1);
    idle(9 * (WORD_CYC + 1) + 10);

    $display("[TB] write on pop cycle");
    applyStimulus(1'b1, 16'h1357);
    applyStimulus(1'b1, 16'h2468);
    while (now + 1 <= busy_until) applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'h9BDF);
    checkOutput("count_simul", count, 1);
    idle(2 * (WORD_CYC + 1) + 10);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 16'h1234);
    applyStimulus(1'b1, 16'h5678);
    while (now < pop_t + 3 * C) applyStimulus(1'b0, 16'h0000);
    resetPhase(3);
    idle(40);
    applyStimulus(1'b1, 16'h00C3);
    idle(WORD_CYC + 10);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 16'($urandom));
    for (int k = 0; k < 1500; k++)
      applyStimulus($urandom_range(0, 49) == 0, 16'($urandom));
    idle(D * (WORD_CYC + 1) + 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
